// File: rtl/fruit_trajectory_ctrl.sv
// Ballistic commander for one fruit: launch, gravity, apex, exit.
// Drives the position tracker and reports how the flight ended.
module fruit_trajectory_ctrl #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int GRAV_DIV = 4,
  parameter int VY_MAX   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       launch,
  input  logic [9:0] launch_vx,
  input  logic [9:0] launch_vy,
  input  logic       launch_dx,
  input  logic       slice_hit,
  input  logic [9:0] posx,
  input  logic [9:0] posy,
  output logic       obj_rst,
  output logic       en,
  output logic       moveclk,
  output logic [9:0] vx,
  output logic [9:0] vy,
  output logic [1:0] dx,
  output logic [1:0] dy,
  output logic       active,
  output logic       done,
  output logic       sliced
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_RISE, S_FALL, S_EXIT
  } state_e;

  localparam int GW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(GRAV_DIV - 1);
  localparam logic [9:0] W_LIM = 10'(SCREEN_W);
  localparam logic [9:0] H_LIM = 10'(SCREEN_H);
  localparam logic [9:0] V_MAX = 10'(VY_MAX);

  state_e state_q, state_d;
  logic obj_rst_q, obj_rst_d;
  logic en_q, en_d;
  logic moveclk_q, moveclk_d;
  logic [9:0] vx_q, vx_d;
  logic [9:0] vy_q, vy_d;
  logic [1:0] dx_q, dx_d;
  logic [1:0] dy_q, dy_d;
  logic active_q, active_d;
  logic done_q, done_d;
  logic sliced_q, sliced_d;
  logic [GW-1:0] gcnt_q, gcnt_d;

  logic flight, flight_d;
  logic exit_scr, leave;
  logic g_step, apex;

  assign flight = (state_q == S_RISE) || (state_q == S_FALL);
  assign exit_scr = ((state_q == S_FALL) && (posy >= H_LIM))
                 || (posx >= W_LIM)
                 || ((dx_q == 2'b10) && (posx < vx_q));
  assign leave  = flight && (slice_hit || exit_scr);
  assign g_step = (gcnt_q == G_LAST);
  // Top guard: turn over early so an upward move never wraps posy.
  assign apex = (state_q == S_RISE) && moveclk_q
             && ((posy < vy_q) || (g_step && (vy_q <= 10'd1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      obj_rst_q <= 1'b0;
      en_q      <= 1'b0;
      moveclk_q <= 1'b0;
      vx_q      <= '0;
      vy_q      <= '0;
      dx_q      <= 2'b00;
      dy_q      <= 2'b00;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      sliced_q  <= 1'b0;
      gcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      obj_rst_q <= obj_rst_d;
      en_q      <= en_d;
      moveclk_q <= moveclk_d;
      vx_q      <= vx_d;
      vy_q      <= vy_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      active_q  <= active_d;
      done_q    <= done_d;
      sliced_q  <= sliced_d;
      gcnt_q    <= gcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (launch) state_d = S_ARM;
      S_ARM:  state_d = (vy_q == '0) ? S_FALL : S_RISE;
      S_RISE: begin
        if (leave)     state_d = S_EXIT;
        else if (apex) state_d = S_FALL;
      end
      S_FALL: if (leave) state_d = S_EXIT;
      S_EXIT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vx_d      = vx_q;
    vy_d      = vy_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    gcnt_d    = gcnt_q;
    sliced_d  = sliced_q;
    flight_d  = (state_d == S_RISE) || (state_d == S_FALL);
    obj_rst_d = (state_d == S_ARM);
    en_d      = flight_d;
    active_d  = flight_d;
    done_d    = (state_d == S_EXIT);
    moveclk_d = tick && flight && flight_d;
    if ((state_q == S_IDLE) && launch) begin
      vx_d     = launch_vx;
      vy_d     = launch_vy;
      dx_d     = launch_dx ? 2'b11 : 2'b10;
      dy_d     = 2'b10;
      gcnt_d   = '0;
      sliced_d = 1'b0;
    end
    if ((state_q == S_ARM) && (vy_q == '0)) begin
      vy_d = 10'd1;
      dy_d = 2'b11;
    end
    if (leave) begin
      sliced_d = slice_hit;
    end else if (flight && moveclk_q) begin
      gcnt_d = g_step ? '0 : gcnt_q + 1'b1;
      if (state_q == S_RISE) begin
        if (apex)        dy_d = 2'b11;
        else if (g_step) vy_d = vy_q - 10'd1;
      end else if (g_step) begin
        vy_d = (vy_q >= V_MAX) ? V_MAX : vy_q + 10'd1;
      end
    end
  end

  assign obj_rst = obj_rst_q;
  assign en      = en_q;
  assign moveclk = moveclk_q;
  assign vx      = vx_q;
  assign vy      = vy_q;
  assign dx      = dx_q;
  assign dy      = dy_q;
  assign active  = active_q;
  assign done    = done_q;
  assign sliced  = sliced_q;

endmodule

// File: tb/tb_fruit_trajectory_ctrl.sv
// Bench for fruit_trajectory_ctrl: flight-level model, tracker
// emulation, directed scenarios and a randomized run.
module tb_fruit_trajectory_ctrl;

  localparam int SW = 640;
  localparam int SH = 480;
  localparam int GD = 4;
  localparam int VM = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic launch = 1'b0;
  logic [9:0] launch_vx = '0;
  logic [9:0] launch_vy = '0;
  logic launch_dx = 1'b0;
  logic slice_hit = 1'b0;
  logic [9:0] posx = '0;
  logic [9:0] posy = '0;
  logic obj_rst, en, moveclk, active, done, sliced;
  logic [9:0] vx, vy;
  logic [1:0] dx, dy;

  fruit_trajectory_ctrl #(
    .SCREEN_W(SW), .SCREEN_H(SH),
    .GRAV_DIV(GD), .VY_MAX(VM)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .launch(launch), .launch_vx(launch_vx),
    .launch_vy(launch_vy), .launch_dx(launch_dx),
    .slice_hit(slice_hit), .posx(posx), .posy(posy),
    .obj_rst(obj_rst), .en(en), .moveclk(moveclk),
    .vx(vx), .vy(vy), .dx(dx), .dy(dy),
    .active(active), .done(done), .sliced(sliced)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t",
                  name, act, exp, $time);
  endtask

  // Flight-level model of what the outputs must be.
  typedef enum {M_IDLE, M_ARM, M_UP, M_DOWN, M_END} mstage_e;
  mstage_e ms = M_IDLE;
  mstage_e m_ns;
  int moves = 0;
  int e_vx = 0;
  int e_vy = 0;
  logic [1:0] e_dx = 2'b00;
  logic [1:0] e_dy = 2'b00;
  bit e_mc, e_sl;
  bit m_air, m_off, m_cut, m_mcp, m_step;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      ms = M_IDLE; moves = 0;
      e_vx = 0; e_vy = 0;
      e_dx = 2'b00; e_dy = 2'b00;
      e_mc = 0; e_sl = 0;
    end else begin
      m_air = (ms == M_UP) || (ms == M_DOWN);
      m_mcp = e_mc;
      m_ns  = ms;
      m_off = m_air && (((ms == M_DOWN) && (posy >= SH))
              || (posx >= SW)
              || ((e_dx == 2'b10) && (posx < e_vx)));
      m_cut = m_air && slice_hit;
      case (ms)
        M_IDLE: if (launch) begin
          e_vx = launch_vx; e_vy = launch_vy;
          e_dx = launch_dx ? 2'b11 : 2'b10;
          e_dy = 2'b10; moves = 0; e_sl = 0;
          m_ns = M_ARM;
        end
        M_ARM: if (e_vy == 0) begin
          e_vy = 1; e_dy = 2'b11; m_ns = M_DOWN;
        end else m_ns = M_UP;
        M_UP, M_DOWN: begin
          if (m_cut || m_off) begin
            e_sl = m_cut; m_ns = M_END;
          end else if (m_mcp) begin
            moves++;
            m_step = (moves % GD) == 0;
            if (ms == M_UP) begin
              if (posy < e_vy || (m_step && e_vy == 1)) begin
                e_dy = 2'b11; m_ns = M_DOWN;
              end else if (m_step) e_vy--;
            end else if (m_step) begin
              e_vy = (e_vy + 1 > VM) ? VM : e_vy + 1;
            end
          end
        end
        default: m_ns = M_IDLE;
      endcase
      e_mc = tick && m_air
          && (m_ns == M_UP || m_ns == M_DOWN);
      ms = m_ns;
    end
  end

  logic [29:0] dut_vec, exp_vec;
  bit e_fly;
  assign dut_vec = {obj_rst, en, moveclk, vx, vy,
                    dx, dy, active, done, sliced};

  initial forever begin
    @(negedge clk);
    e_fly = (ms == M_UP) || (ms == M_DOWN);
    exp_vec = {ms == M_ARM, e_fly, e_mc,
               e_vx[9:0], e_vy[9:0], e_dx, e_dy,
               e_fly, ms == M_END, e_sl};
    check("model", {2'b00, dut_vec}, {2'b00, exp_vec});
  end

  // Tracker emulation and per-cycle stimulus.
  int tx = 0, ty = 0, x0 = 0, y0 = 0;
  int pvx, pvy;
  logic [1:0] pdx, pdy;
  bit pend_rst, pend_mv, track, rnd;
  int tick_per = 0;
  int tcnt = 0;

  function automatic logic [9:0] clamp(input int v);
    if (v < 0) return 10'd0;
    if (v > 1023) return 10'd1023;
    return v[9:0];
  endfunction

  task automatic cyc();
    @(negedge clk);
    if (pend_rst) begin
      tx = x0; ty = y0;
    end else if (pend_mv && track) begin
      tx += (pdx == 2'b11) ? pvx : -pvx;
      ty += (pdy == 2'b11) ? pvy : -pvy;
    end
    pend_rst = obj_rst; pend_mv = moveclk;
    pvx = vx; pvy = vy; pdx = dx; pdy = dy;
    if (obj_rst && rnd) begin
      x0 = $urandom_range(0, 660);
      y0 = $urandom_range(0, 500);
    end
    posx = clamp(tx); posy = clamp(ty);
    launch = 0; slice_hit = 0;
    if (tick_per > 0) begin
      tick = (tcnt % tick_per) == 0; tcnt++;
    end else tick = 0;
    if (rnd) begin
      rst = $urandom_range(0, 700) == 0;
      tick = $urandom_range(0, 2) == 0;
      slice_hit = $urandom_range(0, 150) == 0;
      if ($urandom_range(0, 15) == 0) begin
        launch = 1;
        launch_vx = 10'($urandom_range(0, 40));
        launch_vy = 10'($urandom_range(0, 25));
        launch_dx = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic set_pos(input int x, input int y);
    tx = x; ty = y; x0 = x; y0 = y;
    posx = clamp(x); posy = clamp(y);
  endtask

  task automatic go(input int lvx, input int lvy,
                    input bit ldx);
    launch = 1;
    launch_vx = 10'(lvx);
    launch_vy = 10'(lvy);
    launch_dx = ldx;
  endtask

  task automatic wait_mc();
    int b = 0;
    do begin cyc(); b++; end
    while (!moveclk && b < 100);
    if (!moveclk) check("mc_timeout", moveclk, 1);
  endtask

  int exp_vy[4] = '{3, 2, 1, 1};
  logic [1:0] exp_dy[4] = '{2'b10, 2'b10, 2'b10, 2'b11};
  int mcs;

  initial begin
    // reset
    rst = 1;
    repeat (3) cyc();
    check("rst_vec", {2'b00, dut_vec}, 0);
    rst = 0;
    cyc();

    // rise with gravity, posy held at 200
    set_pos(100, 200);
    go(3, 4, 1);
    tick_per = 10; tcnt = 1;
    cyc();
    check("arm_obj_rst", obj_rst, 1);
    check("arm_dx", dx, 2'b11);
    check("arm_dy", dy, 2'b10);
    for (int m = 1; m <= 16; m++) begin
      wait_mc(); cyc();
      if (m % 4 == 0) begin
        check("rise_vy", vy, exp_vy[m/4-1]);
        check("rise_dy", dy, exp_dy[m/4-1]);
      end
    end
    check("fall_active", active, 1);

    // fall accelerates to the cap, then exits bottom
    tick_per = 2; tcnt = 0;
    for (int m = 17; m <= 80; m++) begin
      wait_mc(); cyc();
      if (m == 36) check("fall_vy6", vy, 6);
      if (m == 76) check("fall_vy16", vy, 16);
      if (m == 80) check("fall_sat", vy, 16);
    end
    set_pos(100, 480);
    cyc();
    check("bot_done", done, 1);
    check("bot_sliced", sliced, 0);
    check("bot_en", en, 0);
    cyc();
    check("bot_pulse", done, 0);
    repeat (2) cyc();

    // left launch that would wrap posx
    tick_per = 1; tcnt = 0;
    set_pos(4, 200);
    go(5, 4, 0);
    cyc();
    check("left_obj_rst", obj_rst, 1);
    cyc();
    check("left_active", active, 1);
    cyc();
    check("left_done", done, 1);
    check("left_sliced", sliced, 0);
    check("left_mc", moveclk, 0);
    mcs = 0;
    repeat (10) begin cyc(); mcs += moveclk; end
    check("left_no_mc", mcs, 0);

    // vy=0 goes straight to fall; slice beats bottom exit
    tick_per = 0;
    set_pos(100, 100);
    go(2, 0, 1);
    cyc(); cyc();
    check("vy0_dy", dy, 2'b11);
    check("vy0_vy", vy, 1);
    check("vy0_active", active, 1);
    set_pos(100, 480);
    slice_hit = 1;
    cyc();
    check("slice_done", done, 1);
    check("slice_sliced", sliced, 1);
    repeat (3) cyc();
    check("sliced_hold", sliced, 1);
    check("done_low", done, 0);

    // relaunch ignored in rise; top guard forces apex
    set_pos(100, 200);
    go(3, 9, 1);
    cyc(); cyc();
    go(7, 2, 1);
    cyc();
    check("ign_vx", vx, 3);
    check("ign_vy", vy, 9);
    check("ign_obj_rst", obj_rst, 0);
    set_pos(100, 5);
    tick = 1;
    cyc();
    check("guard_mc", moveclk, 1);
    cyc();
    check("guard_dy", dy, 2'b11);
    check("guard_vy", vy, 9);
    rst = 1;
    cyc();
    check("midrst_vec", {2'b00, dut_vec}, 0);
    rst = 0;
    cyc();
    check("midrst_done", done, 0);

    // randomized flights with a moving tracker
    track = 1; rnd = 1;
    repeat (4000) cyc();
    rnd = 0; rst = 0; launch = 0;
    slice_hit = 0; tick = 0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fruit_trajectory_ctrl.md
Name: fruit_trajectory_ctrl

Overview:
Ballistic motion commander for one fruit object. It drives the velocity, direction, enable, strobe and reset inputs of the per-object position tracker, and reads back the tracker's posx/posy. It launches an object, applies gravity (upward speed decays, apex turnaround, downward speed grows to a cap), and ends the flight on a slice or when the object leaves the screen. Sits between the game spawner/slice detector and the position tracker.

Parameters:
SCREEN_W, 640, horizontal exit bound (pixels)
SCREEN_H, 480, vertical exit bound (pixels)
GRAV_DIV, 4, move ticks per 1-unit gravity step (>=1)
VY_MAX, 16, terminal falling speed (pixels per move)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tick  in  1  one-cycle move strobe from the frame/move divider
launch  in  1  one-cycle launch request; honoured only in IDLE
launch_vx  in  10  horizontal speed
launch_vy  in  10  initial upward speed
launch_dx  in  1  1 = move right, 0 = move left
slice_hit  in  1  slice detector hit for this object
posx  in  10  current x from position tracker
posy  in  10  current y from position tracker
obj_rst  out  1  tracker reset pulse (reloads initial position)
en  out  1  tracker enable
moveclk  out  1  tracker move strobe
vx  out  10  speed to tracker
vy  out  10  speed to tracker
dx  out  2  tracker x direction code (2'b11 inc, 2'b10 dec)
dy  out  2  tracker y direction code (2'b10 up, 2'b11 down)
active  out  1  object in flight (RISE or FALL)
done  out  1  one-cycle flight-finished pulse
sliced  out  1  registered with done: 1 = ended by slice, 0 = left screen

Behaviour:
- All outputs registered. Reset: state IDLE; obj_rst=0, en=0, moveclk=0, vx=0, vy=0, dx=2'b00, dy=2'b00, active=0, done=0, sliced=0; gravity counter 0. Reset in any state aborts the flight with no done pulse.
- States: IDLE, ARM, RISE, FALL, EXIT.
- IDLE: launch=1 latches vx=launch_vx, vy=launch_vy, dx=launch_dx ? 2'b11 : 2'b10, dy=2'b10, clears gravity counter, goes to ARM. launch is ignored in every other state.
- ARM (1 cycle): obj_rst=1. Next state is RISE. If the latched vy==0, next state is FALL with dy=2'b11 and vy=1.
- RISE/FALL: en=1, active=1. moveclk = registered (tick & state in {RISE,FALL}), so it goes high one cycle after tick. No moveclk in IDLE, ARM or EXIT.
- Velocity update happens on the same edge the tracker consumes moveclk. The tracker always moves with the vx/vy/dx/dy values held during the moveclk-high cycle.
- Gravity: each moveclk cycle increments the gravity counter. When the counter reaches GRAV_DIV-1 it wraps to 0 and a gravity step occurs.
  - RISE step: if vy>1, vy decrements by 1. If vy==1 (apex), vy stays 1, dy becomes 2'b11 and state becomes FALL.
  - FALL step: vy = min(vy+1, VY_MAX), saturating with no wrap.
- Top guard (RISE only): if posy < vy during a moveclk cycle, force the apex transition that cycle (dy=2'b11, FALL, vy unchanged) so posy never underflows.
- Exit conditions, evaluated every cycle in RISE/FALL:
  - FALL and posy >= SCREEN_H.
  - posx >= SCREEN_W.
  - dx==2'b10 and posx < vx (a further left move would wrap).
  Any exit condition moves to EXIT.
- Slice: slice_hit in RISE/FALL moves to EXIT with sliced=1. slice_hit outside RISE/FALL is ignored. If slice_hit and a screen exit occur in the same cycle, the slice takes priority (sliced=1).
- EXIT (1 cycle): en=0, active=0, done=1, sliced set per cause. Next state is IDLE. vx/vy/dx/dy hold their last values. sliced holds until the next launch; done is a single-cycle pulse.
- Latency: launch at cycle N gives obj_rst at N+1 and active from N+2. Exit detected at cycle M gives done at M+1.

Test Plan:
- Reset mid-FALL (vy=7): assert rst -> next cycle all outputs at reset values, state IDLE, no done pulse.
- Launch vx=3, dx=1, vy=4, GRAV_DIV=4, posy fed back at 200 with ticks every 10 cycles -> obj_rst one cycle later, dx=2'b11, dy=2'b10; vy follows 4,3,2,1 every 4 moves; on the 16th move dy=2'b11, state FALL, vy=1.
- FALL with VY_MAX=16, ticks continue -> vy rises by 1 every 4 moves and saturates at 16. When posy fed back reaches 480, done=1 for one cycle, sliced=0, en=0.
- Launch left with vx=5, fed posx=4 -> EXIT on the next evaluation, done=1, sliced=0; no moveclk is issued after that cycle.
- slice_hit in the same cycle that posy=480 in FALL -> done=1, sliced=1. A launch asserted during RISE is ignored: vx/vy unchanged, no obj_rst.
- Launch with vy=0 -> ARM then directly FALL with dy=2'b11, vy=1. RISE with vy=9 and fed posy=5 -> forced apex, dy=2'b11, vy stays 9.
